// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks in-flight writers behind ID, picks forwarding sources
//               for the two ID operands and raises load-use / no-forwarding
//               stalls. Keeps a saturating count of stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_LEN = 4,
  parameter int DEPTH        = 3,
  parameter int LOAD_READY   = 1,
  parameter int R0_ZERO      = 1,
  localparam int SEL_LEN     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    forward_EN,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] src1_ID,
  input  logic [REG_ADDR_LEN-1:0] src2_ID,
  input  logic                    src1_used,
  input  logic                    src2_used,
  input  logic [REG_ADDR_LEN-1:0] dest_ID,
  input  logic                    WB_EN_ID,
  input  logic                    MEM_R_EN_ID,
  input  logic                    flush,
  output logic                    hazard_detected,
  output logic [SEL_LEN-1:0]      reg1_sel,
  output logic [SEL_LEN-1:0]      reg2_sel,
  output logic                    issue,
  output logic [15:0]             stall_count
);

  // Stage pipeline: index 0 is the instruction that just left ID.
  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH-1:0]        r_wb_en;
  logic [DEPTH-1:0]        r_is_load;
  logic [REG_ADDR_LEN-1:0] r_dest [DEPTH];
  logic [15:0]             r_stall_count;

  logic [DEPTH-1:0]        w_match1;
  logic [DEPTH-1:0]        w_match2;
  logic [SEL_LEN-1:0]      w_fwd_sel1;
  logic [SEL_LEN-1:0]      w_fwd_sel2;
  logic                    w_load_haz1;
  logic                    w_load_haz2;
  logic                    w_haz_any;
  logic                    w_src1_zero;
  logic                    w_src2_zero;

  // Register 0 reads never depend on an in-flight writer when it is hardwired.
  assign w_src1_zero = (R0_ZERO != 0) && (src1_ID == '0);
  assign w_src2_zero = (R0_ZERO != 0) && (src2_ID == '0);

  // Per-stage match of each ID source against live, writing entries.
  always_comb begin
    w_match1 = '0;
    w_match2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_match1[k] = src1_used && r_valid[k] && r_wb_en[k] &&
                    (r_dest[k] == src1_ID) && !w_src1_zero;
      w_match2[k] = src2_used && r_valid[k] && r_wb_en[k] &&
                    (r_dest[k] == src2_ID) && !w_src2_zero;
    end
  end

  // Youngest match wins; walking oldest-to-youngest lets the last hit stick.
  // The load check is taken from that same youngest producer.
  always_comb begin
    w_fwd_sel1  = '0;
    w_fwd_sel2  = '0;
    w_load_haz1 = 1'b0;
    w_load_haz2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_match1[k]) begin
        w_fwd_sel1  = SEL_LEN'(k + 1);
        w_load_haz1 = r_is_load[k] && (k < LOAD_READY);
      end
      if (w_match2[k]) begin
        w_fwd_sel2  = SEL_LEN'(k + 1);
        w_load_haz2 = r_is_load[k] && (k < LOAD_READY);
      end
    end
  end

  // Stall decision, issue and operand selects; reset and flush gate them off.
  always_comb begin
    if (forward_EN) begin
      w_haz_any = w_load_haz1 || w_load_haz2;
    end else begin
      w_haz_any = (|w_match1) || (|w_match2);
    end
    hazard_detected = !rst && id_valid && !flush && w_haz_any;
    issue           = !rst && id_valid && !flush && !w_haz_any;
    reg1_sel        = (rst || !forward_EN) ? '0 : w_fwd_sel1;
    reg2_sel        = (rst || !forward_EN) ? '0 : w_fwd_sel2;
  end

  // Valid bits shift every cycle; a non-issuing cycle inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], issue};
    end
  end

  // Payload shifts unconditionally; it is only meaningful where valid is set.
  always_ff @(posedge clk) begin
    r_wb_en   <= {r_wb_en[DEPTH-2:0], WB_EN_ID};
    r_is_load <= {r_is_load[DEPTH-2:0], MEM_R_EN_ID};
    r_dest[0] <= dest_ID;
    for (int i = 1; i < DEPTH; i++) begin
      r_dest[i] <= r_dest[i-1];
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (hazard_detected && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard
//               (DEPTH=3, LOAD_READY=1, R0_ZERO=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        forward_EN;
  logic        id_valid;
  logic [3:0]  src1_ID;
  logic [3:0]  src2_ID;
  logic        src1_used;
  logic        src2_used;
  logic [3:0]  dest_ID;
  logic        WB_EN_ID;
  logic        MEM_R_EN_ID;
  logic        flush;
  logic        hazard_detected;
  logic [1:0]  reg1_sel;
  logic [1:0]  reg2_sel;
  logic        issue;
  logic [15:0] stall_count;

  typedef struct packed {
    logic        hz;
    logic        iss;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [15:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_sc;
  int          checks;
  int          errors;

  hazard_scoreboard #(
    .REG_ADDR_LEN(4),
    .DEPTH       (3),
    .LOAD_READY  (1),
    .R0_ZERO     (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .forward_EN     (forward_EN),
    .id_valid       (id_valid),
    .src1_ID        (src1_ID),
    .src2_ID        (src2_ID),
    .src1_used      (src1_used),
    .src2_used      (src2_used),
    .dest_ID        (dest_ID),
    .WB_EN_ID       (WB_EN_ID),
    .MEM_R_EN_ID    (MEM_R_EN_ID),
    .flush          (flush),
    .hazard_detected(hazard_detected),
    .reg1_sel       (reg1_sel),
    .reg2_sel       (reg2_sel),
    .issue          (issue),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2, input logic [3:0] d,
                        input logic wb, input logic ld);
    id_valid    = v;
    src1_ID     = s1;
    src1_used   = u1;
    src2_ID     = s2;
    src2_used   = u2;
    dest_ID     = d;
    WB_EN_ID    = wb;
    MEM_R_EN_ID = ld;
  endtask

  // Push the expectation for the current inputs, compare mid-cycle, then
  // advance one clock and update the expected stall counter.
  task automatic step(input logic hz, input logic iss, input logic [1:0] s1, input logic [1:0] s2);
    exp_t e;
    exp_q.push_back({hz, iss, s1, s2, exp_sc});
    @(negedge clk);
    e = exp_q.pop_front();
    chk("hazard_detected", 16'(hazard_detected), 16'(e.hz));
    chk("issue",           16'(issue),           16'(e.iss));
    chk("reg1_sel",        16'(reg1_sel),        16'(e.s1));
    chk("reg2_sel",        16'(reg2_sel),        16'(e.s2));
    chk("stall_count",     stall_count,          e.sc);
    if (rst) exp_sc = 16'd0;
    else if (e.hz && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 2'd0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_sc     = 16'd0;
    rst        = 1'b1;
    flush      = 1'b0;
    forward_EN = 1'b1;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held with a busy ID: all outputs quiet, counter zero
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1);
    step(1'b0, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    idle(1);

    // ALU producer forwarded from stage 0 then stage 1, then stage 2
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd1, 2'd0);
    set_id(1'b1, 4'd1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 2'd1);
    set_id(1'b0, 4'd1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 2'd2);
    idle(3);

    // Load-use on src2: one stall cycle, then forward from stage 1
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd9, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 2'd1);
    step(1'b0, 1'b1, 2'd0, 2'd2);
    idle(3);

    // Forwarding disabled: wait until the producer leaves all stages
    forward_EN = 1'b0;
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    idle(3);
    forward_EN = 1'b1;

    // Same dest in two stages: youngest wins; r0 is never tracked
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd1, 2'd0);
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    idle(3);

    // Flush during a load-use stall squashes ID; stage 0 must be a bubble
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    flush = 1'b1;
    step(1'b0, 1'b0, 2'd1, 2'd0);
    flush = 1'b0;
    set_id(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd2, 2'd0);
    idle(3);

    // Reset mid-stall with three live entries
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    forward_EN = 1'b0;
    set_id(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    rst = 1'b1;
    set_id(1'b1, 4'd10, 1'b1, 4'd11, 1'b1, 4'd12, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    step(1'b0, 1'b1, 2'd0, 2'd0);
    forward_EN = 1'b1;
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_ADDR_LEN, default 4, the register-address width (2**REG_ADDR_LEN registers).
REQ-002 SHALL provide parameter DEPTH, default 3, the number of tracked stages after ID (index 0 = EXE … DEPTH-1 = WB); legal range 2..8.
REQ-003 SHALL provide parameter LOAD_READY, default 1, the lowest stage index whose load result is forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL provide parameter R0_ZERO, default 1, meaning register 0 is hardwired zero and never tracked.
REQ-005 SHALL define SEL_LEN = clog2(DEPTH+1).
REQ-006 SHALL have ports (name  direction  width  meaning):
clk  in  1  single clock, rising edge;
rst  in  1  reset, synchronous, active-high;
forward_EN  in  1  1 = forwarding enabled;
id_valid  in  1  ID holds a real instruction;
src1_ID, src2_ID  in  REG_ADDR_LEN  ID source registers;
src1_used, src2_used  in  1  source actually read (0 for immediates or unused operands);
dest_ID  in  REG_ADDR_LEN  ID destination;
WB_EN_ID  in  1  ID instruction writes back;
MEM_R_EN_ID  in  1  ID instruction is a load;
flush  in  1  branch taken, squash ID;
hazard_detected  out  1  freeze PC and IF/ID;
reg1_sel, reg2_sel  out  SEL_LEN  0 = register file, k = stage k-1;
issue  out  1  ID instruction enters stage 0 this cycle;
stall_count  out  16  saturating count of stall cycles.

Function
REQ-007 SHALL hold DEPTH entries {valid, dest, wb_en, is_load} in a shift pipeline.
REQ-008 SHALL advance each rising edge: entry[i] <= entry[i-1] for i >= 1; entry[0] <= ID instruction if issue, else bubble (valid=0).
REQ-009 SHALL assert issue = id_valid & ~hazard_detected & ~flush, combinationally.
REQ-010 SHALL count a source as matching entry k when source used, entry valid, wb_en=1, dest equal, and not (R0_ZERO and source = 0).
REQ-011 SHALL, with forward_EN=1, select the youngest (lowest k) matching entry; regN_sel = k+1, or 0 if no match.
REQ-012 SHALL, with forward_EN=1, flag a load-use hazard when the youngest match is is_load with k < LOAD_READY.
REQ-013 SHALL, with forward_EN=0, flag a hazard on any match in any stage and drive both sels to 0.
REQ-014 SHALL assert hazard_detected = id_valid & ~flush & (hazard on src1 or src2), combinationally.
REQ-015 SHALL give flush priority over hazard: hazard_detected=0, issue=0, bubble inserted.
REQ-016 SHALL drive sel outputs from current state and ID inputs regardless of hazard (consumers ignore them while stalled).
REQ-017 SHALL increment stall_count on each cycle with hazard_detected=1, saturating at 16'hFFFF.
REQ-018 SHALL let a stalled instruction re-evaluate every cycle; the stall ends on the cycle the producer reaches a forwardable stage (or leaves the pipeline when forward_EN=0).
REQ-019 SHALL treat a matching entry with the same dest in several stages by REQ-011 (youngest wins), including for load checks.
REQ-020 SHALL keep WB_EN_ID=0 instructions in the pipeline as non-matching entries.

Reset
REQ-021 SHALL, while rst=1 at a rising edge, clear all entry valid bits and stall_count to 0.
REQ-022 SHALL drive hazard_detected=0, issue=0, reg1_sel=0 and reg2_sel=0 while rst=1, regardless of other inputs.
REQ-023 SHALL override any in-progress stall or flush with reset and resume normal operation on the first cycle after rst=0.

Verification (DEPTH=3, LOAD_READY=1, R0_ZERO=1)
REQ-024 SHALL verify: ADD r1 issued, next ID reads r1 -> no stall, reg1_sel=1; one cycle later reg1_sel=2.
REQ-025 SHALL verify: LOAD r2 issued, next ID reads r2 as src2 -> hazard_detected=1 for exactly 1 cycle, then reg2_sel=2, issue=1, stall_count=1.
REQ-026 SHALL verify: forward_EN=0, ADD r3 issued, next ID reads r3 -> hazard_detected=1 for 3 cycles, then issue=1 with reg1_sel=0.
REQ-027 SHALL verify: r4 written by entries 0 and 1, ID reads r4 -> reg1_sel=1; ID with dest r0 followed by a read of r0 -> sel=0, no stall.
REQ-028 SHALL verify: flush=1 during a load-use stall -> hazard_detected=0, issue=0, entry[0] bubble next cycle.
REQ-029 SHALL verify: rst=1 mid-stall with 3 valid entries -> next cycle all entries invalid, stall_count=0, hazard_detected=0.
